spi_slave_ctrl: RTL and testbench

// - Serial front end of the SPI-slave/single-port-RAM subsystem. Deserialises MOSI frames into 10-bit

---
 rtl/spi_slave_pkg.sv | 47 ++++
 rtl/spi_slave_ctrl_if.sv | 31 +++
 rtl/spi_rx_shifter.sv | 57 +++++
 rtl/spi_slave_ctrl.sv | 116 +++++++++++
 tb/tb_spi_slave_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_pkg
// Brief   : Shared constants, state encoding and command decode for the
//           SPI-slave serial front end.
// Revision: 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    localparam int RX_WIDTH_DEF  = 10;
    localparam int ADDR_SIZE_DEF = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_chk_cmd   = 3'd1;
    localparam logic [2:0] c_st_write     = 3'd2;
    localparam logic [2:0] c_st_read_add  = 3'd3;
    localparam logic [2:0] c_st_read_data = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = c_st_idle,
        ST_CHK_CMD   = c_st_chk_cmd,
        ST_WRITE     = c_st_write,
        ST_READ_ADD  = c_st_read_add,
        ST_READ_DATA = c_st_read_data
    } state_t;

    // Only the first command bit is on the wire when the branch is taken, so
    // the second bit of a read is anticipated from whether an address was seen.
    function automatic state_t cmd_state(input logic first_bit, input logic rd_addr_seen);
        state_t w_st;
        w_st = ST_WRITE;
        case ({first_bit, rd_addr_seen})
            CMD_WR_ADDR, CMD_WR_DATA: w_st = ST_WRITE;
            CMD_RD_ADDR:              w_st = ST_READ_ADD;
            CMD_RD_DATA:              w_st = ST_READ_DATA;
            default:                  w_st = ST_WRITE;
        endcase
        return w_st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_ctrl_if
// Brief   : SPI pins plus RAM-side receive/transmit handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_slave_ctrl_if
    import spi_slave_pkg::*;
#(
    parameter int RX_WIDTH  = RX_WIDTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [0:RX_WIDTH-1]  rx_data;
    logic                 rx_valid;
    logic [0:ADDR_SIZE-1] tx_data;
    logic                 tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface
`default_nettype wire

// File: rtl/spi_rx_shifter.sv
`default_nettype none
// ============================================================================
// Module  : spi_rx_shifter
// Brief   : Serial-in/parallel-out frame receiver with saturating bit count
//           and a one-cycle completion strobe.
// Revision: 1.0 - initial release
// ============================================================================
module spi_rx_shifter
    import spi_slave_pkg::*;
#(
    parameter int RX_WIDTH = RX_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_shift_en,
    input  logic                i_clear,
    input  logic                i_serial,
    output logic [0:RX_WIDTH-1] o_word,
    output logic                o_done,
    output logic                o_full
);
    localparam int                 c_cnt_w = $clog2(RX_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(RX_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(RX_WIDTH);

    logic [0:RX_WIDTH-1] r_shift;
    logic [0:RX_WIDTH-1] r_word;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_shift_en && (r_cnt != c_full)) begin
                r_shift <= {r_shift[1:RX_WIDTH-1], i_serial};
                r_cnt   <= r_cnt + 1'b1;
                // Publish the frame on the edge that captures its last bit.
                if (r_cnt == c_last) begin
                    r_word <= {r_shift[1:RX_WIDTH-1], i_serial};
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_word = r_word;
    assign o_done = r_done;
    assign o_full = (r_cnt == c_full);
endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_ctrl
// Brief   : SPI slave front end: command FSM, frame receive and MISO readback.
// Revision: 1.0 - initial release
// ============================================================================
module spi_slave_ctrl
    import spi_slave_pkg::*;
#(
    parameter int RX_WIDTH  = RX_WIDTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    spi_slave_ctrl_if.slave bus
);
    localparam int                    c_tx_cnt_w = $clog2(ADDR_SIZE + 1);
    localparam logic [c_tx_cnt_w-1:0] c_tx_last  = c_tx_cnt_w'(ADDR_SIZE);

    state_t                r_state;
    logic                  r_rd_addr_seen;
    logic                  r_miso;
    logic                  r_tx_active;
    logic                  r_tx_done;
    logic [c_tx_cnt_w-1:0] r_tx_cnt;
    logic [0:ADDR_SIZE-1]  r_tx_shift;

    logic                  w_shift_en;
    logic                  w_clear;
    logic                  w_rx_done;
    logic                  w_rx_full;
    logic                  w_tx_wait;
    logic [0:RX_WIDTH-1]   w_rx_word;

    assign w_shift_en = (r_state != ST_IDLE) && !bus.SS_n;
    assign w_clear    = (r_state == ST_IDLE) || bus.SS_n;
    assign w_tx_wait  = (r_state == ST_READ_DATA) && w_rx_full && !r_tx_active && !r_tx_done;

    spi_rx_shifter #(
        .RX_WIDTH (RX_WIDTH)
    ) u_rx_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_shift_en (w_shift_en),
        .i_clear    (w_clear),
        .i_serial   (bus.MOSI),
        .o_word     (w_rx_word),
        .o_done     (w_rx_done),
        .o_full     (w_rx_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_rd_addr_seen <= 1'b0;
            r_miso         <= 1'b0;
            r_tx_active    <= 1'b0;
            r_tx_done      <= 1'b0;
            r_tx_cnt       <= '0;
            r_tx_shift     <= '0;
        end else begin
            // The address flag tracks completed frames only, so it is updated
            // independently of a simultaneous deselect.
            if ((r_state == ST_READ_ADD) && w_rx_done) begin
                r_rd_addr_seen <= 1'b1;
            end
            if (r_tx_active && (r_tx_cnt == c_tx_last)) begin
                r_rd_addr_seen <= 1'b0;
            end

            if (bus.SS_n && (r_state != ST_IDLE)) begin
                r_state     <= ST_IDLE;
                r_miso      <= 1'b0;
                r_tx_active <= 1'b0;
                r_tx_done   <= 1'b0;
                r_tx_cnt    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!bus.SS_n) begin
                            r_state <= ST_CHK_CMD;
                        end
                    end
                    ST_CHK_CMD: begin
                        r_state <= cmd_state(bus.MOSI, r_rd_addr_seen);
                    end
                    ST_READ_DATA: begin
                        if (w_tx_wait && bus.tx_valid) begin
                            r_tx_active <= 1'b1;
                            r_tx_cnt    <= c_tx_cnt_w'(1);
                            r_miso      <= bus.tx_data[0];
                            r_tx_shift  <= {bus.tx_data[1:ADDR_SIZE-1], 1'b0};
                        end else if (r_tx_active) begin
                            if (r_tx_cnt == c_tx_last) begin
                                r_tx_active <= 1'b0;
                                r_tx_done   <= 1'b1;
                                r_miso      <= 1'b0;
                            end else begin
                                r_tx_cnt   <= r_tx_cnt + 1'b1;
                                r_miso     <= r_tx_shift[0];
                                r_tx_shift <= {r_tx_shift[1:ADDR_SIZE-1], 1'b0};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.MISO     = r_miso;
    assign bus.rx_data  = w_rx_word;
    assign bus.rx_valid = w_rx_done;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_ctrl
// Brief   : Directed self-checking bench for the SPI slave front end.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_slave_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    spi_slave_ctrl_if #(.RX_WIDTH(10), .ADDR_SIZE(8)) bus ();

    spi_slave_ctrl #(
        .RX_WIDTH  (10),
        .ADDR_SIZE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // First bit on MOSI is f[9]; a deselect on the last bit discards the frame.
    task automatic send_frame(input logic [9:0] f, input logic abort_last, input string tag);
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            bus.MOSI = f[i];
            if (i == 0) begin
                check({tag, "_early"}, 32'(bus.rx_valid), 32'd0);
                if (abort_last) bus.SS_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.MOSI = 1'b0;
        if (abort_last) begin
            check({tag, "_novalid"}, 32'(bus.rx_valid), 32'd0);
        end else begin
            check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
            check({tag, "_data"}, 32'(bus.rx_data), 32'(f));
        end
        @(negedge clk);
        check({tag, "_single"}, 32'(bus.rx_valid), 32'd0);
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_byte;
        checks   = 0;
        failures = 0;
        rst          = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        rst = 1'b1;

        // Write address
        send_frame(10'b00_1010_0101, 1'b0, "wr_addr");
        end_frame();

        // Write data with a spurious tx_valid held throughout
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        send_frame(10'b01_1111_0000, 1'b0, "wr_data");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wr_spurious_miso", 32'(bus.MISO), 32'd0);
        end
        bus.tx_valid = 1'b0;
        end_frame();

        // Read address then read data
        send_frame(10'b10_1010_0101, 1'b0, "rd_addr");
        end_frame();
        send_frame(10'b11_0000_0000, 1'b0, "rd_data");
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hC3;
        exp_byte     = 8'hC3;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rd_miso_bit%0d", k), 32'(bus.MISO), 32'(exp_byte[7-k]));
            if (k == 0) bus.tx_data = 8'h00;
            if (k == 2) bus.tx_valid = 1'b0;
        end
        @(negedge clk);
        check("rd_miso_after", 32'(bus.MISO), 32'd0);
        @(negedge clk);
        check("rd_miso_after2", 32'(bus.MISO), 32'd0);
        end_frame();

        // Address flag was cleared: an 11 frame now goes to READ_ADD, no MISO
        send_frame(10'b11_0000_0000, 1'b0, "rd_again");
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rd_cleared_miso", 32'(bus.MISO), 32'd0);
        end
        bus.tx_valid = 1'b0;
        end_frame();

        // Abort after 5 bits, then a full frame
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.MOSI = (k == 1) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(bus.rx_valid), 32'd0);
        end
        send_frame(10'b01_0110_1001, 1'b0, "post_abort");
        end_frame();

        // Deselect on the same edge as bit 10
        send_frame(10'b00_1100_1100, 1'b1, "ss_on_last");
        end_frame();

        // Read data with reset during MISO bit 4 (address flag set by rd_again)
        send_frame(10'b11_0101_0101, 1'b0, "rd_rst");
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rd_rst_miso", 32'(bus.MISO), 32'd1);
            if (k == 3) rst = 1'b0;
        end
        @(negedge clk);
        check("rst_mid_miso", 32'(bus.MISO), 32'd0);
        check("rst_mid_rx_valid", 32'(bus.rx_valid), 32'd0);
        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.SS_n     = 1'b1;
        @(negedge clk);

        // Address flag cleared by reset: 11 frame lands in READ_ADD
        send_frame(10'b11_1111_1111, 1'b0, "post_rst");
        bus.tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_miso", 32'(bus.MISO), 32'd0);
        end
        bus.tx_valid = 1'b0;
        end_frame();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
